// File: rtl/puf_rsp_uart_tx.sv
// Buffers PUF (rsp_pos, rsp_neg) pairs in a small FIFO and streams each one out
// as a 10-byte UART 8N1 frame: sync byte, frame index, then the two response words MSB byte first.
module puf_rsp_uart_tx #(
  parameter int          CLOCK_FREQUENCY = 300_000_000,
  parameter int          BAUD_RATE       = 115_200,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_pos,
  input  logic [31:0] rsp_neg,
  output logic        uart_txd,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  frame_idx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W        = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state;
  logic [71:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic [79:0]         frame_sr;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic [2:0]          next_bit;
  logic [3:0]          byte_cnt;
  logic [7:0]          cur_byte;
  logic                pop;
  logic                push;
  logic                baud_end;
  logic                frame_done;
  logic                idle_next;

  // A full FIFO still accepts a push in the cycle the LOAD state pops the head.
  assign pop        = (state == S_LOAD);
  assign push       = rsp_valid && ((count < CNT_W'(FIFO_DEPTH)) || pop);
  assign baud_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_done = (state == S_STOP) && baud_end && (byte_cnt == 4'd9);
  assign idle_next  = (count == '0) && ((state == S_IDLE) || frame_done);
  assign cur_byte   = frame_sr[79:72];
  assign next_bit   = bit_cnt + 3'd1;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {frame_idx, rsp_pos, rsp_neg};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      uart_txd  <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      frame_idx <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_sr  <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      count <= count_next;
      busy  <= !idle_next || (count_next != '0);

      if (push) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        frame_idx <= frame_idx + 8'd1;
      end else if (rsp_valid) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          frame_sr <= {SYNC_BYTE, fifo_mem[rd_ptr]};
          byte_cnt <= 4'd0;
          baud_cnt <= '0;
          uart_txd <= 1'b0;
          state    <= S_START;
        end

        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            uart_txd <= cur_byte[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= S_STOP;
            end else begin
              bit_cnt  <= next_bit;
              uart_txd <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_cnt == 4'd9) begin
              // Line stays high; the next frame's LOAD cycle is the only gap.
              state <= (count != '0) ? S_LOAD : S_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              frame_sr <= {frame_sr[71:0], 8'h00};
              uart_txd <= 1'b0;
              state    <= S_START;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

endmodule
